// File: rtl/l1_tag_lookup.sv
// Two-stage 4-way tag lookup: set read on cycle 0, hit/victim/MRU update on cycle 1; fixed latency 1.
// Never stalls; fill/invalidate writes are forwarded so stage 2 never sees stale tag/valid state.

module sram_1r1w #(
  parameter int DATA_WIDTH = 21,
  parameter int SIZE       = 32,
  parameter int ADDR_WIDTH = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);
  logic [DATA_WIDTH-1:0] mem [SIZE];

  // Read-before-write: a same-edge write is not visible on rd_data.
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end
endmodule

module l1_tag_lookup #(
  parameter int NUM_SETS        = 32,
  parameter int SET_INDEX_WIDTH = $clog2(NUM_SETS),
  parameter int TAG_WIDTH       = 21
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       request_valid_i,
  input  logic [SET_INDEX_WIDTH-1:0] request_set_i,
  input  logic [TAG_WIDTH-1:0]       request_tag_i,
  output logic                       response_valid_o,
  output logic                       cache_hit_o,
  output logic [1:0]                 hit_way_o,
  output logic [1:0]                 victim_way_o,
  output logic [SET_INDEX_WIDTH-1:0] response_set_o,
  output logic [TAG_WIDTH-1:0]       response_tag_o,
  output logic [SET_INDEX_WIDTH-1:0] lru_set_o,
  output logic                       lru_access_o,
  output logic                       lru_update_mru_o,
  output logic [1:0]                 lru_new_mru_way_o,
  input  logic [1:0]                 lru_way_i,
  input  logic                       fill_en_i,
  input  logic [SET_INDEX_WIDTH-1:0] fill_set_i,
  input  logic [1:0]                 fill_way_i,
  input  logic [TAG_WIDTH-1:0]       fill_tag_i,
  input  logic                       invalidate_en_i,
  input  logic [SET_INDEX_WIDTH-1:0] invalidate_set_i,
  input  logic [1:0]                 invalidate_way_i
);
  logic [NUM_SETS-1:0][3:0] valid_arr;
  logic [TAG_WIDTH-1:0]     rd_tag [4];

  logic [3:0]           s0_valid;
  logic [3:0]           s0_fwd;
  logic                 s1_vld;
  logic [3:0]           s1_valid;
  logic [3:0]           s1_fwd;
  logic [TAG_WIDTH-1:0] s1_fwd_tag;

  logic [TAG_WIDTH-1:0] eff_tag [4];
  logic [3:0]           eff_valid;
  logic [3:0]           way_hit;
  logic [1:0]           hit_enc;

  for (genvar g = 0; g < 4; g++) begin : g_way
    sram_1r1w #(
      .DATA_WIDTH(TAG_WIDTH),
      .SIZE      (NUM_SETS)
    ) u_tag_sram (
      .clk    (clk),
      .rd_addr(request_set_i),
      .rd_data(rd_tag[g]),
      .wr_en  (fill_en_i && (fill_way_i == 2'(g))),
      .wr_addr(fill_set_i),
      .wr_data(fill_tag_i)
    );
  end

  // Invalidate is applied after fill so it wins on a same set/way collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_arr <= '0;
    end else begin
      if (fill_en_i)       valid_arr[fill_set_i][fill_way_i]             <= 1'b1;
      if (invalidate_en_i) valid_arr[invalidate_set_i][invalidate_way_i] <= 1'b0;
    end
  end

  // Cycle-0 view of the requested set including writes landing on this edge.
  always_comb begin
    s0_valid = valid_arr[request_set_i];
    s0_fwd   = '0;
    if (fill_en_i && (fill_set_i == request_set_i)) begin
      s0_valid[fill_way_i] = 1'b1;
      s0_fwd[fill_way_i]   = 1'b1;
    end
    if (invalidate_en_i && (invalidate_set_i == request_set_i))
      s0_valid[invalidate_way_i] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld         <= 1'b0;
      s1_valid       <= '0;
      s1_fwd         <= '0;
      s1_fwd_tag     <= '0;
      response_set_o <= '0;
      response_tag_o <= '0;
    end else begin
      s1_vld         <= request_valid_i;
      s1_valid       <= s0_valid;
      s1_fwd         <= s0_fwd;
      s1_fwd_tag     <= fill_tag_i;
      response_set_o <= request_set_i;
      response_tag_o <= request_tag_i;
    end
  end

  // Stage-2 view: writes in this cycle to the latched set override the registered state.
  always_comb begin
    for (int w = 0; w < 4; w++) begin
      eff_tag[w]   = s1_fwd[w] ? s1_fwd_tag : rd_tag[w];
      eff_valid[w] = s1_valid[w];
      if (fill_en_i && (fill_set_i == response_set_o) && (fill_way_i == 2'(w))) begin
        eff_tag[w]   = fill_tag_i;
        eff_valid[w] = 1'b1;
      end
      if (invalidate_en_i && (invalidate_set_i == response_set_o) && (invalidate_way_i == 2'(w)))
        eff_valid[w] = 1'b0;
      way_hit[w] = eff_valid[w] && (eff_tag[w] == response_tag_o);
    end
  end

  always_comb begin
    hit_enc      = 2'd0;
    victim_way_o = lru_way_i;
    for (int w = 3; w >= 0; w--) begin
      if (way_hit[w])    hit_enc      = 2'(w);
      if (!eff_valid[w]) victim_way_o = 2'(w);
    end
  end

  assign response_valid_o  = s1_vld;
  assign cache_hit_o       = s1_vld && (|way_hit);
  assign hit_way_o         = cache_hit_o ? hit_enc : 2'd0;
  assign lru_set_o         = request_set_i;
  assign lru_access_o      = request_valid_i;
  assign lru_update_mru_o  = response_valid_o && cache_hit_o;
  assign lru_new_mru_way_o = hit_way_o;
endmodule
